pifo_last_rank_tracker: RTL and testbench

- Downstream neighbour of the WRR rank-calc stage.
- Watches PIFO dequeue events and keeps, per egress port, the most recent dequeued 32-bit rank word.
- Drives that word back to the rank calculator's last_pkt_info inputs, so a port that stalled resumes from the current round.
- Rejects stale (older-round) dequeues using overflow-epoch-aware comparison; CPU can read and clear entries.

---
 rtl/pifo_rank_pkg.sv | 30 +++
 rtl/pifo_last_rank_tracker_if.sv | 38 +++
 rtl/rank_key_cmp.sv | 20 ++
 rtl/pifo_last_rank_tracker.sv | 190 +++++++++++++++++++
 tb/tb_pifo_last_rank_tracker.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pifo_rank_pkg.sv
// Rank-word layout shared by the WRR rank calculator, the PIFO and the
// last-rank tracker. A rank word is {valid, rank[18:0], reserved[11:0]};
// the low 13 rank bits form the {overflow epoch, round} ordering key.
package pifo_rank_pkg;

    localparam int VALID_BIT = 31;
    localparam int RANK_LSB  = 12;
    localparam int RANK_W    = 19;
    localparam int RSVD_W    = 12;
    localparam int ROUND_W   = 11;
    localparam int OVF_W     = 2;
    localparam int CLASS_W   = 5;
    localparam int DATA_W    = 32;
    localparam int KEY_W     = OVF_W + ROUND_W;
    localparam int PORT_W    = 3;

    typedef logic [KEY_W-1:0] rank_key_t;

    typedef struct packed {
        logic              valid;
        logic [RANK_W-1:0] rank;
        logic [RSVD_W-1:0] rsvd;
    } rank_word_t;

    // Ordering key of a rank word: {ovf, round} taken from the low rank bits.
    function automatic rank_key_t rank_key(input rank_word_t w);
        return w.rank[KEY_W-1:0];
    endfunction

endpackage

// File: rtl/pifo_last_rank_tracker_if.sv
// Bundle of the dequeue-event, CPU-access and last_pkt_info signals of the
// last-rank tracker. master = event/CPU source side, slave = the tracker.
interface pifo_last_rank_tracker_if
    import pifo_rank_pkg::*;
#(
    parameter int NUM_PORTS = 5,
    parameter int DATA_W    = 32
);
    // Dequeue events and CPU requests are single-cycle strobes with no
    // backpressure: the tracker accepts every strobe in the cycle it is seen.
    // cpu_out_valid is a one-cycle response pulse following a read request.
    logic                        deq_valid;
    logic [PORT_W-1:0]           deq_port;
    logic [DATA_W-1:0]           deq_data;
    logic                        cpu_valid;
    logic [PORT_W-1:0]           cpu_index;
    logic                        cpu_read_sig;
    logic                        cpu_clear_sig;
    logic                        cpu_out_valid;
    logic [PORT_W-1:0]           cpu_out_index;
    logic [DATA_W-1:0]           cpu_out_val;
    logic [NUM_PORTS*DATA_W-1:0] last_pkt_info;

    modport master (
        output deq_valid, deq_port, deq_data,
        output cpu_valid, cpu_index, cpu_read_sig, cpu_clear_sig,
        input  cpu_out_valid, cpu_out_index, cpu_out_val,
        input  last_pkt_info
    );

    modport slave (
        input  deq_valid, deq_port, deq_data,
        input  cpu_valid, cpu_index, cpu_read_sig, cpu_clear_sig,
        output cpu_out_valid, cpu_out_index, cpu_out_val,
        output last_pkt_info
    );

endinterface

// File: rtl/rank_key_cmp.sv
// Modular newer-or-equal compare of two {ovf, round} keys. The key space is
// treated as a circle: new is newer-or-equal when (new - old) mod 2^W falls
// in the lower half, which makes the epoch 3 -> 0 wrap order correctly.
module rank_key_cmp
    import pifo_rank_pkg::*;
#(
    parameter int W = KEY_W
) (
    input  logic [W-1:0] i_new_key,
    input  logic [W-1:0] i_old_key,
    output logic         o_newer_or_eq
);

    logic [W-1:0] w_diff;

    // Wrapping subtraction; the MSB of the distance marks "older".
    assign w_diff        = i_new_key - i_old_key;
    assign o_newer_or_eq = ~w_diff[W-1];

endmodule

// File: rtl/pifo_last_rank_tracker.sv
// Keeps, per egress port, the most recent dequeued rank word and feeds it
// back to the rank calculator on last_pkt_info. Dequeue events are staged
// one cycle, then compared against the stored key and written (2-cycle
// latency). Older-round events are dropped. CPU can read and clear entries.
// Optional build macro LAST_RANK_STALE_CNT_EN adds per-port stale-drop
// counters that are reported in the low bits of CPU reads.
module pifo_last_rank_tracker
    import pifo_rank_pkg::*;
#(
    parameter int NUM_PORTS = 5,
    parameter int ROUND_W   = pifo_rank_pkg::ROUND_W,
    parameter int OVF_W     = pifo_rank_pkg::OVF_W,
    parameter int DATA_W    = pifo_rank_pkg::DATA_W
) (
    input  logic                     clk_dp,
    input  logic                     rst,
    pifo_last_rank_tracker_if.slave  bus
);

    localparam int KW = OVF_W + ROUND_W;

    // Stage-1 registers (only qualified events are captured).
    logic                 r_s1_valid;
    logic [PORT_W-1:0]    r_s1_port;
    logic [DATA_W-1:0]    r_s1_data;

    // Per-port stored rank words.
    logic [DATA_W-1:0]    r_entry [NUM_PORTS];

    // CPU response registers.
    logic                 r_out_valid;
    logic [PORT_W-1:0]    r_out_index;
    logic [DATA_W-1:0]    r_out_val;

    logic                 w_deq_ok;
    logic                 w_old_valid;
    logic [KW-1:0]        w_old_key;
    logic                 w_newer;
    logic                 w_accept;
    logic                 w_stale;
    logic [NUM_PORTS-1:0] w_wr;
    logic [NUM_PORTS-1:0] w_clr;
    logic [NUM_PORTS-1:0] w_drop;
    logic [DATA_W-1:0]    w_view [NUM_PORTS];
    logic [DATA_W-1:0]    w_rd_word;

`ifdef LAST_RANK_STALE_CNT_EN
    logic [15:0]          r_cnt [NUM_PORTS];
`endif

    // Only in-range ports carrying a valid rank word enter the pipeline.
    assign w_deq_ok = bus.deq_valid
                   && (32'(bus.deq_port) < NUM_PORTS)
                   && bus.deq_data[VALID_BIT];

    // Stage 1: capture the dequeue event.
    always_ff @(posedge clk_dp or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_port  <= '0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_deq_ok;
            if (w_deq_ok) begin
                r_s1_port <= bus.deq_port;
                r_s1_data <= bus.deq_data;
            end
        end
    end

    // Select the stored valid bit and key of the staged event's port.
    always_comb begin
        w_old_valid = 1'b0;
        w_old_key   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_s1_port == PORT_W'(p)) begin
                w_old_valid = r_entry[p][VALID_BIT];
                w_old_key   = r_entry[p][RANK_LSB +: KW];
            end
        end
    end

    rank_key_cmp #(.W(KW)) u_key_cmp (
        .i_new_key     (r_s1_data[RANK_LSB +: KW]),
        .i_old_key     (w_old_key),
        .o_newer_or_eq (w_newer)
    );

    assign w_accept = r_s1_valid && (!w_old_valid || w_newer);
    assign w_stale  = r_s1_valid && w_old_valid && !w_newer;

    // Per-port write, stale-drop and CPU-clear decodes.
    always_comb begin
        w_wr   = '0;
        w_clr  = '0;
        w_drop = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_wr[p]   = w_accept && (r_s1_port == PORT_W'(p));
            w_drop[p] = w_stale  && (r_s1_port == PORT_W'(p));
            w_clr[p]  = bus.cpu_valid && bus.cpu_clear_sig
                     && (bus.cpu_index == PORT_W'(p));
        end
    end

    // Stage 2: update entries; a CPU clear on the same port wins.
    always_ff @(posedge clk_dp or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_entry[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_clr[p]) begin
                    r_entry[p] <= '0;
                end else if (w_wr[p]) begin
                    r_entry[p] <= r_s1_data;
                end
            end
        end
    end

`ifdef LAST_RANK_STALE_CNT_EN
    // Saturating per-port stale-drop counters, cleared with the entry.
    always_ff @(posedge clk_dp or negedge rst) begin
        if (!rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_clr[p]) begin
                    r_cnt[p] <= '0;
                end else if (w_drop[p] && (r_cnt[p] != 16'hFFFF)) begin
                    r_cnt[p] <= r_cnt[p] + 16'd1;
                end
            end
        end
    end

    // CPU view: reserved field replaced by the count; bits [11:8] also
    // flag a count that has outgrown the 12-bit field.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_view[p] = {r_entry[p][DATA_W-1:RSVD_W],
                         r_cnt[p][RSVD_W-1:0] | {{4{|r_cnt[p][15:12]}}, 8'h00}};
        end
    end
`else
    // CPU view is the stored word as-is.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_view[p] = r_entry[p];
        end
    end
`endif

    // CPU read mux; out-of-range indices read as zero.
    always_comb begin
        w_rd_word = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (bus.cpu_index == PORT_W'(p)) begin
                w_rd_word = w_view[p];
            end
        end
    end

    // CPU read response, one cycle after the request (pre-clear value).
    always_ff @(posedge clk_dp or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_val   <= '0;
        end else begin
            r_out_valid <= bus.cpu_valid && bus.cpu_read_sig;
            if (bus.cpu_valid && bus.cpu_read_sig) begin
                r_out_index <= bus.cpu_index;
                r_out_val   <= w_rd_word;
            end
        end
    end

    assign bus.cpu_out_valid = r_out_valid;
    assign bus.cpu_out_index = r_out_index;
    assign bus.cpu_out_val   = r_out_val;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lpi
        assign bus.last_pkt_info[p*DATA_W +: DATA_W] = r_entry[p];
    end

endmodule

// File: tb/tb_pifo_last_rank_tracker.sv
// Bench for pifo_last_rank_tracker: directed scenarios followed by random
// dequeue/CPU traffic, checked against a per-port behavioural model.
module tb_pifo_last_rank_tracker;

    localparam int NP = 5;
    localparam int DW = 32;
    localparam int VW = NP * DW;

    logic clk_dp = 1'b0;
    logic rst    = 1'b0;

    always #5 clk_dp = ~clk_dp;

    pifo_last_rank_tracker_if #(.NUM_PORTS(NP), .DATA_W(DW)) bus ();

    pifo_last_rank_tracker #(
        .NUM_PORTS (NP),
        .ROUND_W   (11),
        .OVF_W     (2),
        .DATA_W    (DW)
    ) dut (
        .clk_dp (clk_dp),
        .rst    (rst),
        .bus    (bus)
    );

    // Reference model state.
    logic [31:0] m_entry [NP];
    int          m_cnt   [NP];
    bit          m_pend_v;
    int          m_pend_port;
    logic [31:0] m_pend_data;
    bit          m_out_v;
    logic [2:0]  m_out_idx;
    logic [31:0] m_out_val;

    int n_checks = 0;
    int n_errors = 0;

    // Newer-or-equal on the 13-bit {ovf, round} key, as circular distance.
    function automatic bit is_fresh(logic [31:0] nw, logic [31:0] od);
        int kn;
        int ko;
        int d;
        kn = int'((nw >> 12) % 32'd8192);
        ko = int'((od >> 12) % 32'd8192);
        d  = (kn - ko + 8192) % 8192;
        return d < 4096;
    endfunction

    function automatic logic [31:0] model_view(int p);
        logic [31:0] v;
`ifdef LAST_RANK_STALE_CNT_EN
        logic [11:0] f;
        f = 12'(m_cnt[p] % 4096);
        if (m_cnt[p] >= 4096) f = f | 12'hF00;
        v = {m_entry[p][31:12], f};
`else
        v = m_entry[p];
`endif
        return v;
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [VW-1:0] v;
        v = '0;
        for (int p = 0; p < NP; p++) v[p*DW +: DW] = m_entry[p];
        return v;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_entry[p] = '0;
            m_cnt[p]   = 0;
        end
        m_pend_v    = 1'b0;
        m_pend_port = 0;
        m_pend_data = '0;
        m_out_v     = 1'b0;
        m_out_idx   = '0;
        m_out_val   = '0;
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_edge();
        int   idx;
        bit   clr;
        idx = int'(bus.cpu_index);
        if (bus.cpu_valid && bus.cpu_read_sig) begin
            m_out_v   = 1'b1;
            m_out_idx = bus.cpu_index;
            m_out_val = (idx < NP) ? model_view(idx) : 32'h0;
        end else begin
            m_out_v = 1'b0;
        end
        clr = bus.cpu_valid && bus.cpu_clear_sig && (idx < NP);
        if (m_pend_v) begin
            if (!m_entry[m_pend_port][31] || is_fresh(m_pend_data, m_entry[m_pend_port]))
                m_entry[m_pend_port] = m_pend_data;
            else if (m_cnt[m_pend_port] < 65535)
                m_cnt[m_pend_port]++;
        end
        if (clr) begin
            m_entry[idx] = '0;
            m_cnt[idx]   = 0;
        end
        m_pend_v    = bus.deq_valid && (int'(bus.deq_port) < NP) && bus.deq_data[31];
        m_pend_port = int'(bus.deq_port);
        m_pend_data = bus.deq_data;
    endtask

    task automatic chk(string tag, logic [VW-1:0] obs, logic [VW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(string tag);
        chk({tag, " last_pkt_info"}, bus.last_pkt_info, model_vec());
        chk({tag, " cpu_out_valid"}, VW'(bus.cpu_out_valid), VW'(m_out_v));
        if (m_out_v) begin
            chk({tag, " cpu_out_index"}, VW'(bus.cpu_out_index), VW'(m_out_idx));
            chk({tag, " cpu_out_val"}, VW'(bus.cpu_out_val), VW'(m_out_val));
        end
    endtask

    task automatic tick(string tag);
        @(posedge clk_dp);
        #1;
        model_edge();
        check_outputs(tag);
    endtask

    task automatic set_deq(bit v, logic [2:0] port, logic [31:0] data);
        bus.deq_valid = v;
        bus.deq_port  = port;
        bus.deq_data  = data;
    endtask

    task automatic set_cpu(bit v, logic [2:0] idx, bit rd, bit clr);
        bus.cpu_valid     = v;
        bus.cpu_index     = idx;
        bus.cpu_read_sig  = rd;
        bus.cpu_clear_sig = clr;
    endtask

    task automatic idle();
        set_deq(1'b0, 3'd0, 32'h0);
        set_cpu(1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] rd_exp;
        idle();
        model_reset();

        // Reset state.
        #12;
        chk("reset last_pkt_info", bus.last_pkt_info, '0);
        chk("reset cpu_out_valid", VW'(bus.cpu_out_valid), '0);
        chk("reset cpu_out_index", VW'(bus.cpu_out_index), '0);
        chk("reset cpu_out_val", VW'(bus.cpu_out_val), '0);
        @(negedge clk_dp);
        rst = 1'b1;

        // First write, 2-cycle latency.
        set_deq(1'b1, 3'd0, 32'h8003_1000);
        tick("first_s1");
        chk("first not yet visible", bus.last_pkt_info, '0);
        idle();
        tick("first_s2");
        chk("first port0", VW'(bus.last_pkt_info[31:0]), VW'(32'h8003_1000));
        chk("first others zero", VW'(bus.last_pkt_info[VW-1:32]), '0);

        // Stale drop on port0.
        set_deq(1'b1, 3'd0, 32'h8000_A000);
        tick("stale_s1");
        idle();
        tick("stale_s2");
        chk("stale port0 unchanged", VW'(bus.last_pkt_info[31:0]), VW'(32'h8003_1000));
        set_cpu(1'b1, 3'd0, 1'b1, 1'b0);
        tick("stale_rd_req");
        idle();
`ifdef LAST_RANK_STALE_CNT_EN
        rd_exp = 32'h8003_1001;
`else
        rd_exp = 32'h8003_1000;
`endif
        chk("stale read valid", VW'(bus.cpu_out_valid), VW'(1'b1));
        chk("stale read val", VW'(bus.cpu_out_val), VW'(rd_exp));
        tick("stale_rd_done");
        chk("read pulse one cycle", VW'(bus.cpu_out_valid), '0);

        // Epoch wrap on port1.
        set_deq(1'b1, 3'd1, 32'h81FF_F000);
        tick("wrap_a");
        set_deq(1'b1, 3'd1, 32'h8000_0000);
        tick("wrap_b");
        chk("wrap ovf3 stored", VW'(bus.last_pkt_info[63:32]), VW'(32'h81FF_F000));
        set_deq(1'b1, 3'd1, 32'h8100_5000);
        tick("wrap_c");
        chk("wrap to epoch0 accepted", VW'(bus.last_pkt_info[63:32]), VW'(32'h8000_0000));
        idle();
        tick("wrap_d");
        chk("epoch2 dropped", VW'(bus.last_pkt_info[63:32]), VW'(32'h8000_0000));

        // Back-to-back on port2.
        set_deq(1'b1, 3'd2, 32'h8000_5000);
        tick("b2b_5");
        set_deq(1'b1, 3'd2, 32'h8000_6000);
        tick("b2b_6");
        chk("b2b round5", VW'(bus.last_pkt_info[95:64]), VW'(32'h8000_5000));
        set_deq(1'b1, 3'd2, 32'h8000_7000);
        tick("b2b_7");
        chk("b2b round6", VW'(bus.last_pkt_info[95:64]), VW'(32'h8000_6000));
        idle();
        tick("b2b_end");
        chk("b2b round7", VW'(bus.last_pkt_info[95:64]), VW'(32'h8000_7000));

        // Read and clear together return the pre-clear value.
        set_cpu(1'b1, 3'd0, 1'b1, 1'b1);
        tick("rdclr");
        idle();
        chk("rdclr val", VW'(bus.cpu_out_val), VW'(rd_exp));
        chk("rdclr entry zero", VW'(bus.last_pkt_info[31:0]), '0);

        // Clear colliding with a stage-2 write on port0: clear wins.
        set_deq(1'b1, 3'd0, 32'h8003_1000);
        tick("coll_a");
        set_deq(1'b1, 3'd0, 32'h8004_0000);
        tick("coll_b");
        set_deq(1'b0, 3'd0, 32'h0);
        set_cpu(1'b1, 3'd0, 1'b0, 1'b1);
        tick("coll_c");
        idle();
        chk("clear wins", VW'(bus.last_pkt_info[31:0]), '0);

        // Out-of-range CPU index and ignored dequeues.
        set_cpu(1'b1, 3'd6, 1'b1, 1'b1);
        set_deq(1'b1, 3'd5, 32'h8001_0000);
        tick("oor_a");
        idle();
        chk("oor read valid", VW'(bus.cpu_out_valid), VW'(1'b1));
        chk("oor read zero", VW'(bus.cpu_out_val), '0);
        set_deq(1'b1, 3'd3, 32'h0003_1000);
        tick("oor_b");
        idle();
        tick("oor_c");
        chk("invalid word ignored", VW'(bus.last_pkt_info[127:96]), '0);

        // Reset while an event sits in stage 1.
        set_deq(1'b1, 3'd4, 32'h8001_1000);
        tick("rst_s1");
        idle();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs("in_reset");
        chk("reset clears entries", bus.last_pkt_info, '0);
        @(negedge clk_dp);
        rst = 1'b1;
        tick("post_rst_a");
        tick("post_rst_b");
        chk("in-flight discarded", VW'(bus.last_pkt_info[159:128]), '0);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            logic [31:0] d;
            d = {($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
                 6'($urandom()), 13'($urandom_range(0, 8191)), 12'($urandom())};
            set_deq($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), d);
            if ($urandom_range(0, 3) == 0)
                set_cpu(1'b1, 3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                        $urandom_range(0, 5) == 0);
            else
                set_cpu(1'b0, 3'd0, 1'b0, 1'b0);
            tick("rand");
        end
        idle();
        tick("drain_a");
        tick("drain_b");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
